// File: rtl/sme_pkg.sv
// Shared definitions for the string-match engine job sequencer: FSM states,
// default buffer sizes and the special pattern characters the engine understands.
package sme_pkg;

    localparam int unsigned DEF_MAX_STR  = 32;
    localparam int unsigned DEF_MAX_PAT  = 8;
    localparam int unsigned DEF_WAIT_MAX = 320;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;

    typedef enum logic [2:0] {
        IDLE,
        STR,
        PAT,
        WAIT,
        DONE
    } state_e;

    function automatic logic len_ok(input int unsigned len, input int unsigned limit);
        return (len != 0) && (len <= limit);
    endfunction

endpackage

// File: rtl/sme_char_buf.sv
// Byte buffer with one synchronous write port and one asynchronous read port.
// Contents are not reset; the host loads them before use.
module sme_char_buf #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sme_job_sequencer.sv
// Host-side driver for one SME: serialises stored string/pattern bytes onto the
// engine port, waits for its result (or times out) and holds it for the host.
module sme_job_sequencer
    import sme_pkg::*;
#(
    parameter int unsigned MAX_STR  = DEF_MAX_STR,
    parameter int unsigned MAX_PAT  = DEF_MAX_PAT,
    parameter int unsigned WAIT_MAX = DEF_WAIT_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic       cfg_sel,
    input  logic [4:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    input  logic       send_string,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       timeout,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_index
);

    localparam int unsigned CW  = $clog2(MAX_STR + 1);
    localparam int unsigned WCW = $clog2(WAIT_MAX + 1);
    localparam int unsigned SAW = $clog2(MAX_STR);
    localparam int unsigned PAW = $clog2(MAX_PAT);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [5:0]     str_len_q, str_len_d;
    logic [3:0]     pat_len_q, pat_len_d;
    logic           res_match_q, res_match_d;
    logic [4:0]     res_index_q, res_index_d;
    logic           timeout_q, timeout_d;
    logic           err_q, err_d;
    logic           isstring_q, isstring_d;
    logic           ispattern_q, ispattern_d;
    logic [7:0]     chardata_q, chardata_d;

    logic           str_we, pat_we, legal_start;
    logic [SAW-1:0] str_raddr;
    logic [PAW-1:0] pat_raddr;
    logic [7:0]     str_rdata, pat_rdata, str_byte, pat_byte;

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    assign str_we = cfg_we & ~cfg_sel & ~busy & (32'(cfg_addr) < MAX_STR);
    assign pat_we = cfg_we &  cfg_sel & ~busy & (32'(cfg_addr) < MAX_PAT);

    assign legal_start = len_ok(32'(pat_len), MAX_PAT) &
                         (~send_string | len_ok(32'(str_len), MAX_STR));

    sme_char_buf #(.DEPTH(MAX_STR), .AW(SAW)) u_str_buf (
        .clk   (clk),
        .we    (str_we),
        .waddr (cfg_addr[SAW-1:0]),
        .wdata (cfg_wdata),
        .raddr (str_raddr),
        .rdata (str_rdata)
    );

    sme_char_buf #(.DEPTH(MAX_PAT), .AW(PAW)) u_pat_buf (
        .clk   (clk),
        .we    (pat_we),
        .waddr (cfg_addr[PAW-1:0]),
        .wdata (cfg_wdata),
        .raddr (pat_raddr),
        .rdata (pat_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        str_len_d   = str_len_q;
        pat_len_d   = pat_len_q;
        res_match_d = res_match_q;
        res_index_d = res_index_q;
        timeout_d   = timeout_q;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal_start) begin
                        state_d   = send_string ? STR : PAT;
                        cnt_d     = '0;
                        str_len_d = str_len;
                        pat_len_d = pat_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STR: begin
                if (cnt_q == CW'(str_len_q) - CW'(1)) begin
                    state_d = PAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PAT: begin
                if (cnt_q == CW'(pat_len_q) - CW'(1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    wait_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                wait_d = wait_q + WCW'(1);
                if (sme_valid) begin
                    state_d     = DONE;
                    res_match_d = sme_match;
                    res_index_d = sme_index;
                    timeout_d   = 1'b0;
                end else if (wait_q == WCW'(WAIT_MAX - 1)) begin
                    state_d     = DONE;
                    res_match_d = 1'b0;
                    res_index_d = '0;
                    timeout_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Engine outputs are flopped, so the read address follows cnt_d; a host write
    // landing on the same edge as start is forwarded so the new byte goes out.
    assign str_raddr = cnt_d[SAW-1:0];
    assign pat_raddr = cnt_d[PAW-1:0];
    assign str_byte  = (str_we && (cfg_addr[SAW-1:0] == str_raddr)) ? cfg_wdata : str_rdata;
    assign pat_byte  = (pat_we && (cfg_addr[PAW-1:0] == pat_raddr)) ? cfg_wdata : pat_rdata;

    always_comb begin
        isstring_d  = (state_d == STR);
        ispattern_d = (state_d == PAT);
        chardata_d  = '0;
        if (state_d == STR) begin
            chardata_d = str_byte;
        end else if (state_d == PAT) begin
            chardata_d = pat_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            str_len_q   <= '0;
            pat_len_q   <= '0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            chardata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            str_len_q   <= str_len_d;
            pat_len_q   <= pat_len_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            isstring_q  <= isstring_d;
            ispattern_q <= ispattern_d;
            chardata_q  <= chardata_d;
        end
    end

    assign err       = err_q;
    assign res_match = res_match_q;
    assign res_index = res_index_q;
    assign timeout   = timeout_q;
    assign isstring  = isstring_q;
    assign ispattern = ispattern_q;
    assign chardata  = chardata_q;

endmodule

// File: tb/tb_sme_job_sequencer.sv
// Self-checking bench for sme_job_sequencer: a table of directed jobs, a mid-job
// reset sequence and random jobs, all checked against a byte-level model of the buffers.
module tb_sme_job_sequencer;
    import sme_pkg::*;

    localparam int WM = 320;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we, cfg_sel;
    logic [4:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic       send_string, start;
    logic       busy, done, err, res_match, timeout;
    logic [4:0] res_index;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       sme_valid, sme_match;
    logic [4:0] sme_index;

    logic [7:0] str_mem [32];
    logic [7:0] pat_mem [8];
    int total = 0;
    int bad   = 0;

    typedef struct {
        string      str_txt;
        string      pat_txt;
        bit         send;
        int         slen;
        int         plen;
        int         k;
        bit         m;
        logic [4:0] idx;
        bit         glitch;
        bit         busy_wr;
        bit         same_wr;
        bit         exp_err;
        bit         exp_m;
        logic [4:0] exp_i;
        bit         exp_to;
    } vec_t;

    vec_t tbl [10];

    sme_job_sequencer #(.MAX_STR(32), .MAX_PAT(8), .WAIT_MAX(WM)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .str_len     (str_len),
        .pat_len     (pat_len),
        .send_string (send_string),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .res_match   (res_match),
        .res_index   (res_index),
        .timeout     (timeout),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .sme_valid   (sme_valid),
        .sme_match   (sme_match),
        .sme_index   (sme_index)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wr(input bit sel, input int addr, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 5'(addr); cfg_wdata = d;
        if (!sel) str_mem[addr] = d;
        else if (addr < 8) pat_mem[addr] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_txt(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) wr(sel, i, s[i]);
    endtask

    task automatic run_job(input bit send, input int slen, input int plen, input int k,
                           input bit m, input logic [4:0] idx, input bit glitch,
                           input bit busy_wr, input bit same_wr, input bit em,
                           input logic [4:0] ei, input bit eto, input string tag);
        logic [9:0] exp_q [$];
        int n, done_c, errs, exp_done;
        @(negedge clk);
        start = 1'b1; send_string = send; str_len = 6'(slen); pat_len = 4'(plen);
        if (same_wr) begin
            cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 5'd0; cfg_wdata = 8'h48;
            str_mem[0] = 8'h48;
        end
        if (send) for (int i = 0; i < slen; i++) exp_q.push_back({2'b10, str_mem[i]});
        for (int i = 0; i < plen; i++) exp_q.push_back({2'b01, pat_mem[i]});
        n = exp_q.size();
        exp_done = (k < WM) ? n + k + 1 : n + WM;
        done_c = -1;
        errs = 0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < n + WM + 8; c++) begin
            if (c > 0) @(negedge clk);
            sme_valid = 1'b0;
            cfg_we = 1'b0;
            if (!busy || err || (isstring && ispattern)) errs++;
            if (c < n) begin
                if ({isstring, ispattern, chardata} !== exp_q[c]) errs++;
            end else if ({isstring, ispattern, chardata} !== 10'd0) begin
                errs++;
            end
            if (done) begin
                done_c = c;
                break;
            end
            if (c == n + k) begin
                sme_valid = 1'b1; sme_match = m; sme_index = idx;
            end
            if (glitch && c == 1) begin
                sme_valid = 1'b1; sme_match = ~em; sme_index = ~ei;
            end
            if (busy_wr && c == 1) begin
                cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 5'd0; cfg_wdata = 8'hA5;
            end
        end
        sme_valid = 1'b0;
        cfg_we = 1'b0;
        chk({tag, ".stream_errs"}, 64'(errs), 64'(0));
        chk({tag, ".done_cycle"}, 64'(done_c), 64'(exp_done));
        chk({tag, ".result"}, 64'({res_match, res_index, timeout}), 64'({em, ei, eto}));
        @(negedge clk);
        chk({tag, ".after"}, 64'({done, busy, res_match, res_index, timeout}),
            64'({2'b00, em, ei, eto}));
    endtask

    task automatic run_bad(input bit send, input int slen, input int plen, input bit em,
                           input logic [4:0] ei, input bit eto, input string tag);
        @(negedge clk);
        start = 1'b1; send_string = send; str_len = 6'(slen); pat_len = 4'(plen);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".err_pulse"}, 64'({err, busy, isstring, ispattern}), 64'(4'b1000));
        @(negedge clk);
        chk({tag, ".after"}, 64'({err, busy, isstring, ispattern, res_match, res_index, timeout}),
            64'({4'b0000, em, ei, eto}));
    endtask

    initial begin
        string s_space, p_caret, p_dot, s_hello;
        bit em, eto, snd, gl;
        logic [4:0] ei, idx;
        int slen, plen, k, r, seen;

        reset = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        str_len = '0; pat_len = '0; send_string = 1'b0; start = 1'b0;
        sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
        em = 1'b0; ei = '0; eto = 1'b0;

        s_space = "ab?cd";        s_space.putc(2, CH_SPACE);
        p_caret = "?ab";          p_caret.putc(0, CH_CARET);
        p_dot   = "x?z";          p_dot.putc(1, CH_DOT);
        s_hello = "hello world?"; s_hello.putc(11, CH_DOLLAR);

        //            str      pat    snd slen plen k       m     idx    gl bw sw err  em  ei     to
        tbl[0] = '{s_space, "cd",    1'b1, 5, 2, 2,      1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  1'b0};
        tbl[1] = '{"",      p_caret, 1'b0, 5, 3, 0,      1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0};
        tbl[2] = '{"",      "",      1'b1, 33, 0, 0,     1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0};
        tbl[3] = '{"",      "",      1'b0, 5, 3, WM + 10, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1};
        tbl[4] = '{"",      p_dot,   1'b1, 5, 3, 5,      1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9,  1'b0};
        tbl[5] = '{"",      "",      1'b0, 5, 3, WM - 1, 1'b1, 5'd17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 1'b0};
        tbl[6] = '{s_hello, "o",     1'b1, 12, 1, 1,     1'b1, 5'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  1'b0};
        tbl[7] = '{"0123456789ABCDEFGHIJKLMNOPQRSTUV", "abcdefgh",
                                     1'b1, 32, 8, 3,     1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0};
        tbl[8] = '{"",      "",      1'b0, 5, 9, 0,      1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0};
        tbl[9] = '{"",      "",      1'b1, 0, 3, 0,      1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_state", 64'({busy, done, err, res_match, res_index, timeout, chardata,
                                isstring, ispattern}), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 64'({busy, done, err, isstring, ispattern, chardata}), 64'(0));

        for (int i = 0; i < 32; i++) wr(1'b0, i, 8'($urandom));
        for (int i = 0; i < 8; i++)  wr(1'b1, i, 8'($urandom));

        for (int v = 0; v < 10; v++) begin
            if (tbl[v].str_txt != "") load_txt(1'b0, tbl[v].str_txt);
            if (tbl[v].pat_txt != "") load_txt(1'b1, tbl[v].pat_txt);
            if (tbl[v].exp_err)
                run_bad(tbl[v].send, tbl[v].slen, tbl[v].plen, tbl[v].exp_m, tbl[v].exp_i,
                        tbl[v].exp_to, $sformatf("vec%0d", v));
            else
                run_job(tbl[v].send, tbl[v].slen, tbl[v].plen, tbl[v].k, tbl[v].m, tbl[v].idx,
                        tbl[v].glitch, tbl[v].busy_wr, tbl[v].same_wr, tbl[v].exp_m,
                        tbl[v].exp_i, tbl[v].exp_to, $sformatf("vec%0d", v));
        end

        // Reset while the third string byte is on the bus.
        @(negedge clk);
        start = 1'b1; send_string = 1'b1; str_len = 6'd5; pat_len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.byte2", 64'({isstring, chardata}), 64'({1'b1, str_mem[2]}));
        #1 reset = 1'b1;
        #1;
        chk("rst.async", 64'({isstring, ispattern, chardata, busy, done, res_match, res_index,
                              timeout}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy || isstring || ispattern) seen++;
        end
        chk("rst.quiet", 64'(seen), 64'(0));
        for (int i = 0; i < 32; i++) wr(1'b0, i, 8'($urandom));
        for (int i = 0; i < 8; i++)  wr(1'b1, i, 8'($urandom));
        run_job(1'b1, 7, 4, 2, 1'b0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b0, "rst.newjob");
        em = 1'b0; ei = 5'd12; eto = 1'b0;

        for (int it = 0; it < 24; it++) begin
            repeat ($urandom_range(1, 4))
                wr(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 8'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    run_bad(1'b1, ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(33, 63)),
                            int'($urandom_range(1, 8)), em, ei, eto, $sformatf("rnd%0d", it));
                else
                    run_bad(1'($urandom_range(0, 1)), int'($urandom_range(1, 32)),
                            ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(9, 15)),
                            em, ei, eto, $sformatf("rnd%0d", it));
            end else begin
                snd  = 1'($urandom_range(0, 1));
                slen = int'($urandom_range(1, 32));
                plen = int'($urandom_range(1, 8));
                r    = int'($urandom_range(0, 19));
                k    = (r == 0) ? WM + 3 : (r == 1) ? WM - 1 : int'($urandom_range(0, 12));
                idx  = 5'($urandom);
                snd  = snd;
                gl   = ((snd ? slen : 0) + plen >= 3) && ($urandom_range(0, 1) == 1);
                em   = (k < WM) ? 1'($urandom) : 1'b0;
                ei   = (k < WM) ? idx : 5'd0;
                eto  = (k >= WM);
                run_job(snd, slen, plen, k, em, idx, gl, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), em, ei, eto, $sformatf("rnd%0d", it));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
